// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver with byte FIFO.
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int MIN_BAUD_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Bit period in clk cycles; very small baud_max values are clamped up.
  function automatic logic [16:0] bit_period(input logic [15:0] baud_max);
    if (baud_max < 16'(MIN_BAUD_MAX))
      return 17'(MIN_BAUD_MAX + 1);
    return {1'b0, baud_max} + 17'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; accepts a push while full when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small byte FIFO, with sticky framing and overrun flags.
// state     | meaning
// IDLE      | line idle, waiting for a synchronized falling edge
// START     | half a bit period in, confirming the start bit
// DATA      | sampling 8 data bits, LSB first, one per bit period
// STOP      | sampling the stop bit; push on high, framing error on low
// WAIT_HIGH | line stuck low after a bad stop bit; wait for it to return high
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] baud_max,
  input  logic        rd_en,
  input  logic        clear_errors,
  output logic [7:0]  rx_data,
  output logic        read_ready,
  output logic        fifo_full,
  output logic        frame_error,
  output logic        overrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  rx_state_t            state;
  logic [16:0]          period;
  logic [16:0]          cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 cnt_done;
  logic                 push;
  logic                 drop;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  assign cnt_done = (cnt == 17'd1);
  assign push     = (state == STOP) && cnt_done && rx_sync;
  assign drop     = push && !rd_en && (fifo_count == CW'(FIFO_DEPTH));
  assign read_ready = !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      period      <= '0;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_error <= 1'b0;
    end else begin
      if (clear_errors) frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            period  <= bit_period(baud_max);
            cnt     <= bit_period(baud_max) >> 1;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (cnt_done) begin
            cnt   <= period;
            state <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        DATA: begin
          if (cnt_done) begin
            shift   <= {rx_sync, shift[DATA_BITS-1:1]};
            cnt     <= period;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        STOP: begin
          if (cnt_done) begin
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 17'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A set event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
    else if (clear_errors)
      overrun <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_en),
    .wdata (shift),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized frames against a queue model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] baud_max;
  logic        rd_en;
  logic        clear_errors;
  logic [7:0]  rx_data;
  logic        read_ready;
  logic        fifo_full;
  logic        frame_error;
  logic        overrun;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .baud_max     (baud_max),
    .rd_en        (rd_en),
    .clear_errors (clear_errors),
    .rx_data      (rx_data),
    .read_ready   (read_ready),
    .fifo_full    (fifo_full),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int period_of(input int b);
    return ((b < 3) ? 3 : b) + 1;
  endfunction

  // Edge at which the stop bit is sampled, counted from the edge after which the start bit was driven:
  // two synchronizer stages plus edge detection, half a period to mid start bit, nine more periods.
  function automatic int push_edge(input int f0, input int p);
    return f0 + 3 + p / 2 + 9 * p;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic after, output int f0);
    int p;
    p  = period_of(int'(baud_max));
    f0 = cyc;
    rx = 1'b0;
    repeat (p) tick;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) tick;
    end
    rx = stop;
    repeat (p) tick;
    rx = after;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick;
  endtask

  task automatic pop_one;
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clear_errors = 1'b0; baud_max = 16'd3;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
    total++; if (read_ready !== 1'b0) $display("FAIL reset_read_ready: got %b want 0", read_ready); else passed++;
    total++; if (fifo_full !== 1'b0) $display("FAIL reset_fifo_full: got %b want 0", fifo_full); else passed++;
    total++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error: got %b want 0", frame_error); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_basic;
    int f0, pe;
    baud_max = 16'd3;
    send_frame(8'h55, 1'b1, 1'b1, f0);
    pe = push_edge(f0, 4);
    wait_until(pe - 1);
    total++; if (read_ready !== 1'b0) $display("FAIL basic_early_ready: got %b want 0", read_ready); else passed++;
    wait_until(pe);
    total++; if (read_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", read_ready); else passed++;
    total++; if (rx_data !== 8'h55) $display("FAIL basic_data: got %h want 55", rx_data); else passed++;
    pop_one;
    total++; if (read_ready !== 1'b0) $display("FAIL basic_pop_ready: got %b want 0", read_ready); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL basic_empty_data: got %h want 00", rx_data); else passed++;
  endtask

  task automatic test_overrun;
    int f0;
    baud_max = 16'd3;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b1, f0);
      wait_until(push_edge(f0, 4));
      tick;
    end
    total++; if (fifo_full !== 1'b1) $display("FAIL ovr_full: got %b want 1", fifo_full); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
    for (int i = 1; i <= 4; i++) begin
      total++; if (rx_data !== 8'(i)) $display("FAIL ovr_pop%0d: got %h want %h", i, rx_data, 8'(i)); else passed++;
      pop_one;
    end
    total++; if (read_ready !== 1'b0) $display("FAIL ovr_drained: got %b want 0", read_ready); else passed++;
    clear_errors = 1'b1;
    tick;
    clear_errors = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_frame_error;
    int f0;
    baud_max = 16'd3;
    send_frame(8'hA5, 1'b0, 1'b0, f0);
    wait_until(push_edge(f0, 4));
    repeat (40) tick;
    total++; if (frame_error !== 1'b1) $display("FAIL fe_flag: got %b want 1", frame_error); else passed++;
    total++; if (read_ready !== 1'b0) $display("FAIL fe_no_push: got %b want 0", read_ready); else passed++;
    rx = 1'b1;
    repeat (60) tick;
    total++; if (read_ready !== 1'b0) $display("FAIL fe_no_retrigger: got %b want 0", read_ready); else passed++;
    send_frame(8'h3C, 1'b1, 1'b1, f0);
    wait_until(push_edge(f0, 4));
    total++; if (rx_data !== 8'h3C) $display("FAIL fe_next_data: got %h want 3c", rx_data); else passed++;
    pop_one;
    clear_errors = 1'b1;
    tick;
    clear_errors = 1'b0;
    total++; if (frame_error !== 1'b0) $display("FAIL fe_clear: got %b want 0", frame_error); else passed++;
  endtask

  task automatic test_glitch;
    int f0;
    baud_max = 16'd5;
    rx = 1'b0;
    tick;
    rx = 1'b1;
    repeat (20) tick;
    total++; if (read_ready !== 1'b0) $display("FAIL glitch_push: got %b want 0", read_ready); else passed++;
    total++; if ({frame_error, overrun} !== 2'b00) $display("FAIL glitch_flags: got %b want 00", {frame_error, overrun}); else passed++;
    send_frame(8'h96, 1'b1, 1'b1, f0);
    wait_until(push_edge(f0, 6));
    total++; if (rx_data !== 8'h96) $display("FAIL glitch_next_data: got %h want 96", rx_data); else passed++;
    pop_one;
  endtask

  task automatic test_full_pop;
    int f0, pe;
    byte unsigned exp_q[$];
    baud_max = 16'd3;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[i]) begin
      send_frame(exp_q[i], 1'b1, 1'b1, f0);
      wait_until(push_edge(f0, 4));
      tick;
    end
    send_frame(8'h77, 1'b1, 1'b1, f0);
    pe = push_edge(f0, 4);
    wait_until(pe - 1);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    total++; if (overrun !== 1'b0) $display("FAIL fullpop_overrun: got %b want 0", overrun); else passed++;
    total++; if (fifo_full !== 1'b1) $display("FAIL fullpop_full: got %b want 1", fifo_full); else passed++;
    foreach (exp_q[i]) begin
      total++; if (rx_data !== exp_q[i]) $display("FAIL fullpop_entry%0d: got %h want %h", i, rx_data, exp_q[i]); else passed++;
      pop_one;
    end
    total++; if (read_ready !== 1'b0) $display("FAIL fullpop_empty: got %b want 0", read_ready); else passed++;
  endtask

  task automatic test_one_entry;
    int f0;
    baud_max = 16'd3;
    send_frame(8'h5A, 1'b1, 1'b1, f0);
    wait_until(push_edge(f0, 4));
    tick;
    send_frame(8'hE1, 1'b1, 1'b1, f0);
    wait_until(push_edge(f0, 4) - 1);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    total++; if (rx_data !== 8'hE1) $display("FAIL one_head: got %h want e1", rx_data); else passed++;
    pop_one;
    total++; if (read_ready !== 1'b0) $display("FAIL one_count: got %b want 0", read_ready); else passed++;
  endtask

  task automatic test_reset_mid;
    int f0, pe;
    baud_max = 16'd3;
    send_frame(8'h99, 1'b1, 1'b1, f0);
    wait_until(push_edge(f0, 4));
    tick;
    baud_max = 16'd0;
    rx = 1'b0;
    repeat (4) tick;
    rx = 1'b1; repeat (4) tick;
    rx = 1'b1; repeat (4) tick;
    rx = 1'b0; repeat (4) tick;
    rst = 1'b1;
    rx  = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    total++; if (read_ready !== 1'b0) $display("FAIL rstmid_empty: got %b want 0", read_ready); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", rx_data); else passed++;
    repeat (4) tick;
    send_frame(8'hC3, 1'b1, 1'b1, f0);
    pe = push_edge(f0, 4);
    wait_until(pe - 1);
    total++; if (read_ready !== 1'b0) $display("FAIL rstmid_early: got %b want 0", read_ready); else passed++;
    wait_until(pe);
    total++; if (rx_data !== 8'hC3) $display("FAIL rstmid_c3: got %h want c3", rx_data); else passed++;
    total++; if (frame_error !== 1'b0) $display("FAIL rstmid_fe: got %b want 0", frame_error); else passed++;
    pop_one;
    total++; if (read_ready !== 1'b0) $display("FAIL rstmid_only_one: got %b want 0", read_ready); else passed++;
  endtask

  task automatic test_random;
    byte unsigned q[$];
    bit exp_fe, exp_ov, bad;
    logic [7:0] b;
    int f0, p, npop;
    clear_errors = 1'b1;
    tick;
    clear_errors = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    for (int n = 0; n < 16; n++) begin
      b        = 8'($urandom);
      baud_max = 16'($urandom_range(0, 7));
      bad      = ($urandom_range(0, 5) == 0);
      p        = period_of(int'(baud_max));
      send_frame(b, !bad, 1'b1, f0);
      wait_until(push_edge(f0, p));
      if (bad) exp_fe = 1'b1;
      else if (q.size() < DEPTH) q.push_back(b);
      else exp_ov = 1'b1;
      total++; if (frame_error !== exp_fe) $display("FAIL rnd%0d_fe: got %b want %b", n, frame_error, exp_fe); else passed++;
      total++; if (overrun !== exp_ov) $display("FAIL rnd%0d_ovr: got %b want %b", n, overrun, exp_ov); else passed++;
      total++; if (fifo_full !== (q.size() == DEPTH)) $display("FAIL rnd%0d_full: got %b want %b", n, fifo_full, q.size() == DEPTH); else passed++;
      total++; if (read_ready !== (q.size() != 0)) $display("FAIL rnd%0d_ready: got %b want %b", n, read_ready, q.size() != 0); else passed++;
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        if (q.size() != 0) begin
          total++; if (rx_data !== q[0]) $display("FAIL rnd%0d_head: got %h want %h", n, rx_data, q[0]); else passed++;
          void'(q.pop_front());
        end
        pop_one;
      end
      repeat (3) tick;
    end
    while (q.size() != 0) begin
      total++; if (rx_data !== q[0]) $display("FAIL rnd_drain: got %h want %h", rx_data, q[0]); else passed++;
      void'(q.pop_front());
      pop_one;
    end
    total++; if (read_ready !== 1'b0) $display("FAIL rnd_final_empty: got %b want 0", read_ready); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overrun;
    test_frame_error;
    test_glitch;
    test_full_pop;
    test_one_entry;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed so far", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx  input  1  serial line, idle high, 8N1 LSB-first, asynchronous to clk.
REQ-005 SHALL have port baud_max  input  16  bit period minus one, in clk cycles.
REQ-006 SHALL have port rd_en  input  1  pop request for the head byte.
REQ-007 SHALL have port clear_errors  input  1  clears the sticky error flags.
REQ-008 SHALL have port rx_data  output  8  head byte of FIFO (show-ahead).
REQ-009 SHALL have port read_ready  output  1  FIFO non-empty.
REQ-010 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port frame_error  output  1  sticky; stop bit sampled low.
REQ-012 SHALL have port overrun  output  1  sticky; byte dropped because FIFO full.

Function
REQ-013 SHALL pass rx through a 2-FF synchronizer; all logic uses the synchronized value only.
REQ-014 SHALL use an effective bit period P = max(baud_max,3)+1 cycles; baud_max is sampled at start-bit detection and held for the frame.
REQ-015 SHALL implement FSM IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: a synchronized 1->0 transition SHALL enter START and load the bit counter with P/2 (floor).
REQ-017 START: at counter expiry, sampled 0 SHALL enter DATA with the counter = P; sampled 1 (glitch) SHALL return to IDLE with no flag set.
REQ-018 DATA: SHALL sample one bit every P cycles into a shift register, LSB first; after the 8th sample, enter STOP.
REQ-019 STOP: sample after P cycles; 1 SHALL push the byte (if not full) and enter IDLE; 0 SHALL discard the byte, set frame_error and enter WAIT_HIGH.
REQ-020 WAIT_HIGH: SHALL stay until synchronized rx = 1, then enter IDLE (break does not retrigger).
REQ-021 Push SHALL occur in the stop-sample cycle; read_ready SHALL be high on the following cycle.
REQ-022 rd_en with read_ready high SHALL pop one byte; rx_data SHALL show the next entry the following cycle; rd_en when empty SHALL be ignored.
REQ-023 Push while full with no pop SHALL drop the new byte and set overrun; the FIFO contents SHALL remain unchanged.
REQ-024 Push and pop in the same cycle while full SHALL both succeed, with no overrun.
REQ-025 Push and pop in the same cycle while holding one entry SHALL leave the count at 1 with the new byte at the head.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-027 clear_errors SHALL clear both flags next cycle; a set event in the same cycle SHALL win.
REQ-028 rx_data SHALL be 8'h00 when empty.

Reset
REQ-029 rst SHALL asynchronously force: FSM=IDLE, synchronizer FFs=1, counters/shift=0, FIFO empty, rx_data=0, read_ready=0, fifo_full=0, frame_error=0, overrun=0.
REQ-030 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL resume only at the next falling edge.

Structure
REQ-031 Package uart_pkg SHALL hold the rx_state_t enum, DATA_BITS=8 and MIN_BAUD_MAX=3.
REQ-032 The FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-033 baud_max=3, send 0x55 -> read_ready rises the cycle after the stop sample, rx_data=0x55, pop -> read_ready=0.
REQ-034 Send 0x01,0x02,0x03,0x04,0x05 without popping (depth 4) -> fifo_full=1, overrun=1, pops return 0x01..0x04, then empty.
REQ-035 Frame 0xA5 with stop bit low, then rx held low 40 cycles -> frame_error=1, no push, no new frame until rx high then next falling edge.
REQ-036 Low glitch of 1 cycle on idle rx -> FSM returns to IDLE, no push, no flags.
REQ-037 Full FIFO, rd_en asserted in the push cycle of a 5th byte 0x77 -> overrun=0, tail=0x77, count=4.
REQ-038 rst asserted in DATA after 3 bits, released, then 0xC3 sent -> only 0xC3 received; baud_max=0 behaves as baud_max=3.
